// File: rtl/edac_log_pkg.sv
// Shared definitions for the EDAC error logger.
// Log entry layout: {uncorr, scrub, addr}.
package edac_log_pkg;

    function automatic int entry_width(input int aw);
        return aw + 2;
    endfunction

    function automatic int ent_uncorr(input int aw);
        return aw + 1;
    endfunction

    function automatic int ent_scrub(input int aw);
        return aw;
    endfunction

endpackage

// File: rtl/edac_log_fifo.sv
// Generic show-ahead synchronous FIFO.
// Head entry is presented on rdata whenever not empty.
module edac_log_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign level = cnt_q;
    assign rdata = empty ? '0 : mem_q[rptr_q];

    // A pop while full frees a slot, so a simultaneous push is accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next-state for pointers and fill level; pointers wrap naturally.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/edac_err_logger.sv
// EDAC decoder monitor: error counters, event log FIFO and IRQ.
// All outputs are registered; inputs act one cycle later.
module edac_err_logger
    import edac_log_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int LOG_DEPTH   = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int CORR_THRESH = 16
) (
    input  logic                              RCLK,
    input  logic                              NGRST,
    input  logic                              DEC_VALID,
    input  logic                              ERROR,
    input  logic                              CORRECTABLE,
    input  logic                              NOW_SCRUBBING,
    input  logic [ADDR_WIDTH-1:0]             ERR_ADDR,
    input  logic                              CLR_CNT,
    input  logic                              LOG_RDEN,
    output logic [entry_width(ADDR_WIDTH)-1:0] LOG_DATA,
    output logic                              LOG_EMPTY,
    output logic [$clog2(LOG_DEPTH):0]        LOG_LEVEL,
    output logic                              LOG_OVF,
    output logic [CNT_WIDTH-1:0]              CORR_CNT,
    output logic [CNT_WIDTH-1:0]              UNCORR_CNT,
    output logic                              IRQ,
    input  logic                              IRQ_ACK
);

    localparam int EW    = entry_width(ADDR_WIDTH);
    localparam int UNC_B = ent_uncorr(ADDR_WIDTH);
    localparam int SCR_B = ent_scrub(ADDR_WIDTH);

    logic                 ev, uncorr, ev_c, ev_u;
    logic                 full, drop;
    logic [EW-1:0]        entry;
    logic [CNT_WIDTH-1:0] corr_q, corr_d, corr_base;
    logic [CNT_WIDTH-1:0] unc_q, unc_d, unc_base;
    logic                 corr_inc, unc_inc, thr_hit;
    logic                 ovf_q, ovf_d;
    logic                 irq_q, irq_d, irq_set;

    assign ev     = DEC_VALID & ERROR;
    assign uncorr = ERROR & ~CORRECTABLE;
    assign ev_c   = ev & ~uncorr;
    assign ev_u   = ev & uncorr;

    // Build the log entry {uncorr, scrub, addr}.
    always_comb begin
        entry                   = '0;
        entry[ADDR_WIDTH-1:0]   = ERR_ADDR;
        entry[SCR_B]            = NOW_SCRUBBING;
        entry[UNC_B]            = uncorr;
    end

    edac_log_fifo #(
        .WIDTH (EW),
        .DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk   (RCLK),
        .rst_n (NGRST),
        .push  (ev),
        .pop   (LOG_RDEN),
        .wdata (entry),
        .rdata (LOG_DATA),
        .empty (LOG_EMPTY),
        .full  (full),
        .level (LOG_LEVEL)
    );

    // Full implies non-empty, so a pop while full always frees a slot.
    assign drop = ev & full & ~LOG_RDEN;

    // Clear first, then count with saturation; IRQ set beats ack.
    always_comb begin
        corr_base = CLR_CNT ? '0 : corr_q;
        unc_base  = CLR_CNT ? '0 : unc_q;
        corr_inc  = ev_c & (corr_base != '1);
        unc_inc   = ev_u & (unc_base != '1);
        corr_d    = corr_base + CNT_WIDTH'(corr_inc);
        unc_d     = unc_base + CNT_WIDTH'(unc_inc);
        thr_hit   = corr_inc & (corr_d == CNT_WIDTH'(CORR_THRESH));
        ovf_d     = (ovf_q & ~CLR_CNT) | drop;
        irq_set   = ev_u | thr_hit | (ovf_d & ~ovf_q);
        irq_d     = irq_set | (irq_q & ~IRQ_ACK);
    end

    // Counter, overflow and interrupt registers.
    always_ff @(posedge RCLK) begin
        if (!NGRST) begin
            corr_q <= '0;
            unc_q  <= '0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            corr_q <= corr_d;
            unc_q  <= unc_d;
            ovf_q  <= ovf_d;
            irq_q  <= irq_d;
        end
    end

    assign CORR_CNT   = corr_q;
    assign UNCORR_CNT = unc_q;
    assign LOG_OVF    = ovf_q;
    assign IRQ        = irq_q;

endmodule
